// File: rtl/alu_exec_unit.sv
//------------------------------------------------------------------------------
// Module      : alu_exec_unit
// Description : MIPS EX-stage ALU control decode, 32-bit ALU with zero flag,
//               PC+4 incrementer and an enable-gated EX/MEM result register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       aluop,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] pc_in,
  output logic [3:0]       aluctrl,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] alu_out_q,
  output logic             zero_q,
  output logic [WIDTH-1:0] pc_plus4_q
);

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ANDI  = 2'b11;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;
  localparam logic [5:0] FUNC_NOR = 6'b100111;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [3:0]       w_ctrl;
  logic [5:0]       w_func_ctrl_sel;
  logic [3:0]       w_rtype_ctrl;
  logic [WIDTH-1:0] w_result;
  logic             w_lt;

  // R-type decode; unknown funct codes fall back to add.
  always_comb begin
    w_func_ctrl_sel = func;
    case (w_func_ctrl_sel)
      FUNC_ADD: w_rtype_ctrl = CTRL_ADD;
      FUNC_SUB: w_rtype_ctrl = CTRL_SUB;
      FUNC_AND: w_rtype_ctrl = CTRL_AND;
      FUNC_OR:  w_rtype_ctrl = CTRL_OR;
      FUNC_SLT: w_rtype_ctrl = CTRL_SLT;
      FUNC_NOR: w_rtype_ctrl = CTRL_NOR;
      default:  w_rtype_ctrl = CTRL_ADD;
    endcase
  end

  always_comb begin
    case (aluop)
      ALUOP_MEM:    w_ctrl = CTRL_ADD;
      ALUOP_BRANCH: w_ctrl = CTRL_SUB;
      ALUOP_RTYPE:  w_ctrl = w_rtype_ctrl;
      ALUOP_ANDI:   w_ctrl = CTRL_AND;
      default:      w_ctrl = CTRL_ADD;
    endcase
  end

  assign w_lt = ($signed(in1) < $signed(in2));

  always_comb begin
    case (w_ctrl)
      CTRL_AND: w_result = in1 & in2;
      CTRL_OR:  w_result = in1 | in2;
      CTRL_ADD: w_result = in1 + in2;
      CTRL_SUB: w_result = in1 - in2;
      CTRL_SLT: w_result = {{(WIDTH-1){1'b0}}, w_lt};
      CTRL_NOR: w_result = ~(in1 | in2);
      default:  w_result = '0;
    endcase
  end

  assign aluctrl  = w_ctrl;
  assign alu_out  = w_result;
  assign zero     = (w_result == '0);
  assign pc_plus4 = pc_in + PC_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out_q  <= '0;
      zero_q     <= 1'b0;
      pc_plus4_q <= '0;
    end else if (en) begin
      alu_out_q  <= w_result;
      zero_q     <= (w_result == '0);
      pc_plus4_q <= pc_in + PC_STEP;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit against a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  aluop;
  logic [5:0]  func;
  logic [31:0] in1, in2, pc_in;
  logic [3:0]  aluctrl;
  logic [31:0] alu_out, pc_plus4, alu_out_q, pc_plus4_q;
  logic        zero, zero_q;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .aluop(aluop), .func(func),
    .in1(in1), .in2(in2), .pc_in(pc_in), .aluctrl(aluctrl),
    .alu_out(alu_out), .zero(zero), .pc_plus4(pc_plus4),
    .alu_out_q(alu_out_q), .zero_q(zero_q), .pc_plus4_q(pc_plus4_q)
  );

  // Reference: the instruction's meaning computed directly, skipping any ctrl encoding.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [5:0] f,
                                              input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return a & b;
    if (f == 6'd32) return a + b;
    if (f == 6'd34) return a - b;
    if (f == 6'd36) return a & b;
    if (f == 6'd37) return a | b;
    if (f == 6'd42) return (sa < sb) ? 32'd1 : 32'd0;
    if (f == 6'd39) return ~(a | b);
    return a + b;
  endfunction

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0110;
    if (op == 2'd3) return 4'b0000;
    if (f == 6'd34) return 4'b0110;
    if (f == 6'd36) return 4'b0000;
    if (f == 6'd37) return 4'b0001;
    if (f == 6'd42) return 4'b0111;
    if (f == 6'd39) return 4'b1100;
    return 4'b0010;
  endfunction

  function automatic logic [5:0] pick_func();
    logic [5:0] table_f [7];
    table_f = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0};
    if ($urandom_range(0, 7) == 0) return 6'($urandom);
    return table_f[$urandom_range(0, 6)];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; aluop = 2'b00; func = 6'd0;
    in1 = 32'd9; in2 = 32'd1; pc_in = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (alu_out_q !== 32'd0) begin n_fail++; $display("FAIL reset_alu_out_q got %h want 0", alu_out_q); end
    n_cmp++; if (zero_q !== 1'b0) begin n_fail++; $display("FAIL reset_zero_q got %b want 0", zero_q); end
    n_cmp++; if (pc_plus4_q !== 32'd0) begin n_fail++; $display("FAIL reset_pc_plus4_q got %h want 0", pc_plus4_q); end
    n_cmp++; if (alu_out !== 32'd10) begin n_fail++; $display("FAIL reset_comb_alu_out got %h want 10", alu_out); end
    n_cmp++; if (pc_plus4 !== 32'h44) begin n_fail++; $display("FAIL reset_comb_pc_plus4 got %h want 44", pc_plus4); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a, b, pc;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic [31:0] pc4;
  } vec_t;

  task automatic test_directed();
    vec_t v [13];
    v[0]  = '{2'b10, 6'b100000, 32'd5, 32'd7, 32'h0, 4'b0010, 32'd12, 1'b0, 32'd4};
    v[1]  = '{2'b01, 6'b000000, 32'h1234, 32'h1234, 32'hFFFFFFFC, 4'b0110, 32'd0, 1'b1, 32'd0};
    v[2]  = '{2'b01, 6'b101010, 32'd3, 32'd5, 32'h100, 4'b0110, 32'hFFFFFFFE, 1'b0, 32'h104};
    v[3]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'h8, 4'b0111, 32'd1, 1'b0, 32'hC};
    v[4]  = '{2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 32'h8, 4'b0111, 32'd0, 1'b1, 32'hC};
    v[5]  = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h10, 4'b0000, 32'h00F000F0, 1'b0, 32'h14};
    v[6]  = '{2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h10, 4'b0001, 32'hFFF0FFF0, 1'b0, 32'h14};
    v[7]  = '{2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h10, 4'b1100, 32'h000F000F, 1'b0, 32'h14};
    v[8]  = '{2'b00, 6'b100010, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFC, 4'b0010, 32'd0, 1'b1, 32'h80000000};
    v[9]  = '{2'b11, 6'b100000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h20, 4'b0000, 32'h00F000F0, 1'b0, 32'h24};
    v[10] = '{2'b10, 6'b000000, 32'd5, 32'd7, 32'h20, 4'b0010, 32'd12, 1'b0, 32'h24};
    v[11] = '{2'b10, 6'b100010, 32'd10, 32'd3, 32'h30, 4'b0110, 32'd7, 1'b0, 32'h34};
    v[12] = '{2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 32'h30, 4'b0111, 32'd1, 1'b0, 32'h34};
    en = 1'b0;
    foreach (v[i]) begin
      @(negedge clk);
      aluop = v[i].op; func = v[i].f; in1 = v[i].a; in2 = v[i].b; pc_in = v[i].pc;
      #1;
      n_cmp++; if (aluctrl !== v[i].ctrl) begin n_fail++; $display("FAIL dir%0d_aluctrl got %b want %b", i, aluctrl, v[i].ctrl); end
      n_cmp++; if (alu_out !== v[i].res) begin n_fail++; $display("FAIL dir%0d_alu_out got %h want %h", i, alu_out, v[i].res); end
      n_cmp++; if (zero !== v[i].z) begin n_fail++; $display("FAIL dir%0d_zero got %b want %b", i, zero, v[i].z); end
      n_cmp++; if (pc_plus4 !== v[i].pc4) begin n_fail++; $display("FAIL dir%0d_pc_plus4 got %h want %h", i, pc_plus4, v[i].pc4); end
    end
    @(negedge clk);
    aluop = 2'b10; func = 6'b100000; in1 = 32'd5; in2 = 32'd7; pc_in = 32'h0; en = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (alu_out_q !== 32'd12) begin n_fail++; $display("FAIL dir_add_alu_out_q got %h want 0000000c", alu_out_q); end
    n_cmp++; if (zero_q !== 1'b0) begin n_fail++; $display("FAIL dir_add_zero_q got %b want 0", zero_q); end
    n_cmp++; if (pc_plus4_q !== 32'd4) begin n_fail++; $display("FAIL dir_add_pc_plus4_q got %h want 4", pc_plus4_q); end
  endtask

  task automatic test_random_comb();
    logic [31:0] er;
    en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      aluop = 2'($urandom); func = pick_func();
      in1 = pick_operand(); in2 = ($urandom_range(0, 9) == 0) ? in1 : pick_operand();
      pc_in = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : {$urandom} & 32'hFFFFFFFC;
      #1;
      er = ref_result(aluop, func, in1, in2);
      n_cmp++; if (aluctrl !== ref_ctrl(aluop, func)) begin n_fail++; $display("FAIL rnd_aluctrl op=%b f=%b got %b want %b", aluop, func, aluctrl, ref_ctrl(aluop, func)); end
      n_cmp++; if (alu_out !== er) begin n_fail++; $display("FAIL rnd_alu_out op=%b f=%b a=%h b=%h got %h want %h", aluop, func, in1, in2, alu_out, er); end
      n_cmp++; if (zero !== (er == 32'd0)) begin n_fail++; $display("FAIL rnd_zero got %b want %b", zero, (er == 32'd0)); end
      n_cmp++; if (pc_plus4 !== pc_in + 32'd4) begin n_fail++; $display("FAIL rnd_pc_plus4 got %h want %h", pc_plus4, pc_in + 32'd4); end
    end
  endtask

  task automatic test_reset_enable();
    @(negedge clk);
    aluop = 2'b10; func = 6'b100000; in1 = 32'd5; in2 = 32'd7; pc_in = 32'h100; en = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (alu_out_q !== 32'd12) begin n_fail++; $display("FAIL re_load_alu_out_q got %h want c", alu_out_q); end
    n_cmp++; if (pc_plus4_q !== 32'h104) begin n_fail++; $display("FAIL re_load_pc_plus4_q got %h want 104", pc_plus4_q); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (alu_out_q !== 32'd0) begin n_fail++; $display("FAIL re_async_alu_out_q got %h want 0", alu_out_q); end
    n_cmp++; if (zero_q !== 1'b0) begin n_fail++; $display("FAIL re_async_zero_q got %b want 0", zero_q); end
    n_cmp++; if (pc_plus4_q !== 32'd0) begin n_fail++; $display("FAIL re_async_pc_plus4_q got %h want 0", pc_plus4_q); end
    @(posedge clk); #1;
    n_cmp++; if (alu_out_q !== 32'd0) begin n_fail++; $display("FAIL re_override_alu_out_q got %h want 0", alu_out_q); end
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (alu_out_q !== 32'd0) begin n_fail++; $display("FAIL re_hold_alu_out_q got %h want 0", alu_out_q); end
    n_cmp++; if (zero_q !== 1'b0) begin n_fail++; $display("FAIL re_hold_zero_q got %b want 0", zero_q); end
    n_cmp++; if (pc_plus4_q !== 32'd0) begin n_fail++; $display("FAIL re_hold_pc_plus4_q got %h want 0", pc_plus4_q); end
    @(negedge clk);
    en = 1'b1; aluop = 2'b01; in1 = 32'h55; in2 = 32'h55;
    @(posedge clk); #1;
    n_cmp++; if (alu_out_q !== 32'd0) begin n_fail++; $display("FAIL re_cap_alu_out_q got %h want 0", alu_out_q); end
    n_cmp++; if (zero_q !== 1'b1) begin n_fail++; $display("FAIL re_cap_zero_q got %b want 1", zero_q); end
    n_cmp++; if (pc_plus4_q !== 32'h104) begin n_fail++; $display("FAIL re_cap_pc_plus4_q got %h want 104", pc_plus4_q); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q, exp_pc;
    logic        exp_z;
    exp_q = alu_out_q; exp_z = zero_q; exp_pc = pc_plus4_q;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      aluop = 2'($urandom); func = pick_func();
      in1 = pick_operand(); in2 = ($urandom_range(0, 5) == 0) ? in1 : pick_operand();
      pc_in = $urandom; en = 1'($urandom);
      if (en) begin
        exp_q  = ref_result(aluop, func, in1, in2);
        exp_z  = (exp_q == 32'd0);
        exp_pc = pc_in + 32'd4;
      end
      @(posedge clk); #1;
      n_cmp++; if (alu_out_q !== exp_q) begin n_fail++; $display("FAIL b2b%0d_alu_out_q en=%b got %h want %h", i, en, alu_out_q, exp_q); end
      n_cmp++; if (zero_q !== exp_z) begin n_fail++; $display("FAIL b2b%0d_zero_q en=%b got %b want %b", i, en, zero_q, exp_z); end
      n_cmp++; if (pc_plus4_q !== exp_pc) begin n_fail++; $display("FAIL b2b%0d_pc_plus4_q en=%b got %h want %h", i, en, pc_plus4_q, exp_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_comb();
    test_reset_enable();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
